// File: rtl/pc_unit.sv
// Program counter, EPC and exception sequencer for the multicycle datapath.
// Selects the next PC, gates writes, and fetches the handler byte on an exception.
module pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               EXC_BASE = 253,
  parameter int               MEM_LAT  = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pc_write_i,
  input  logic             pc_write_cond_i,
  input  logic             branch_cond_i,
  input  logic [2:0]       pc_source_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic [25:0]      jump_index_i,
  input  logic [WIDTH-1:0] mem_data_i,
  input  logic             exc_req_i,
  input  logic [1:0]       exc_code_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             exc_busy_o,
  output logic             exc_mem_rd_o,
  output logic [WIDTH-1:0] exc_mem_addr_o
);

  // state    | meaning
  // IDLE     | normal PC updates, exceptions accepted
  // EXC_RD   | handler byte read strobe, wait counter loaded
  // EXC_WAIT | counting down memory latency
  // EXC_LOAD | pc takes the handler byte from mem_data
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EXC_RD   = 2'd1;
  localparam logic [1:0] EXC_WAIT = 2'd2;
  localparam logic [1:0] EXC_LOAD = 2'd3;

  localparam logic [2:0] MEM_LAT_C = 3'(MEM_LAT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             busy_q, rd_q;
  logic [WIDTH-1:0] next_pc;
  logic [1:0]       exc_off;
  logic             pc_en;

  always_comb begin
    next_pc = pc_q;
    case (pc_source_i)
      3'd0:    next_pc = alu_result_i;
      3'd1:    next_pc = {pc_q[WIDTH-1:28], jump_index_i, 2'b00};
      3'd2:    next_pc = mem_data_i;
      3'd3:    next_pc = alu_out_i;
      3'd4:    next_pc = epc_q;
      default: next_pc = pc_q;
    endcase
  end

  assign pc_en   = pc_write_i | (pc_write_cond_i & branch_cond_i);
  // code 0 is folded onto code 1 so it never addresses below the table
  assign exc_off = (exc_code_i == 2'd0) ? 2'd0 : exc_code_i - 2'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (exc_req_i) begin
          epc_d   = pc_q - WIDTH'(4);
          addr_d  = WIDTH'(EXC_BASE) + WIDTH'(exc_off);
          state_d = EXC_RD;
        end else if (pc_en) begin
          pc_d = next_pc;
        end
      end
      EXC_RD: begin
        cnt_d   = MEM_LAT_C;
        state_d = (MEM_LAT_C == 3'd0) ? EXC_LOAD : EXC_WAIT;
      end
      EXC_WAIT: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = EXC_LOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      EXC_LOAD: begin
        pc_d    = {{(WIDTH-8){1'b0}}, mem_data_i[7:0]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      rd_q    <= (state_d == EXC_RD);
    end
  end

  assign pc_o           = pc_q;
  assign epc_o          = epc_q;
  assign exc_busy_o     = busy_q;
  assign exc_mem_rd_o   = rd_q;
  assign exc_mem_addr_o = addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: next-PC mux, write gating, exception sequence,
// latency at MEM_LAT 0/1/3 and reset during a sequence.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, pc_write_cond, branch_cond;
  logic [2:0]  pc_source;
  logic [31:0] alu_result, alu_out, mem_data;
  logic [25:0] jump_index;
  logic        exc_req;
  logic [1:0]  exc_code;

  logic [31:0] pc1, epc1, addr1, pc0, epc0, addr0, pc3, epc3, addr3;
  logic        busy1, rd1, busy0, rd0, busy3, rd3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .EXC_BASE(253), .MEM_LAT(1)) u_l1 (
    .clk_i(clk), .reset_i(reset), .pc_write_i(pc_write), .pc_write_cond_i(pc_write_cond),
    .branch_cond_i(branch_cond), .pc_source_i(pc_source), .alu_result_i(alu_result),
    .alu_out_i(alu_out), .jump_index_i(jump_index), .mem_data_i(mem_data),
    .exc_req_i(exc_req), .exc_code_i(exc_code), .pc_o(pc1), .epc_o(epc1),
    .exc_busy_o(busy1), .exc_mem_rd_o(rd1), .exc_mem_addr_o(addr1));

  pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .EXC_BASE(253), .MEM_LAT(0)) u_l0 (
    .clk_i(clk), .reset_i(reset), .pc_write_i(pc_write), .pc_write_cond_i(pc_write_cond),
    .branch_cond_i(branch_cond), .pc_source_i(pc_source), .alu_result_i(alu_result),
    .alu_out_i(alu_out), .jump_index_i(jump_index), .mem_data_i(mem_data),
    .exc_req_i(exc_req), .exc_code_i(exc_code), .pc_o(pc0), .epc_o(epc0),
    .exc_busy_o(busy0), .exc_mem_rd_o(rd0), .exc_mem_addr_o(addr0));

  pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .EXC_BASE(253), .MEM_LAT(3)) u_l3 (
    .clk_i(clk), .reset_i(reset), .pc_write_i(pc_write), .pc_write_cond_i(pc_write_cond),
    .branch_cond_i(branch_cond), .pc_source_i(pc_source), .alu_result_i(alu_result),
    .alu_out_i(alu_out), .jump_index_i(jump_index), .mem_data_i(mem_data),
    .exc_req_i(exc_req), .exc_code_i(exc_code), .pc_o(pc3), .epc_o(epc3),
    .exc_busy_o(busy3), .exc_mem_rd_o(rd3), .exc_mem_addr_o(addr3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b0; pc_write_cond = 1'b0; branch_cond = 1'b0;
    pc_source = 3'd0; alu_result = '0; alu_out = '0; mem_data = '0;
    jump_index = '0; exc_req = 1'b0; exc_code = 2'd0;
    tick(); tick();
    chk("rst_pc", pc1, 32'h0);
    chk("rst_epc", epc1, 32'h0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_rd", {31'd0, rd1}, 32'd0);
    chk("rst_addr", addr1, 32'h0);

    reset = 1'b0; alu_result = 32'h4; pc_write = 1'b1;
    tick(); chk("mux0", pc1, 32'h4);

    alu_result = 32'h4000_0010;
    tick(); chk("set_pc", pc1, 32'h4000_0010);
    pc_source = 3'd1; jump_index = 26'h000_0100;
    tick(); chk("jump", pc1, 32'h4000_0400);
    pc_write = 1'b0;

    pc_write_cond = 1'b1; branch_cond = 1'b0; pc_source = 3'd3; alu_out = 32'h80;
    tick(); chk("cond_nt", pc1, 32'h4000_0400);
    branch_cond = 1'b1;
    tick(); chk("cond_t", pc1, 32'h80);
    pc_write_cond = 1'b0; branch_cond = 1'b0;

    pc_source = 3'd2; mem_data = 32'h1234_5678; pc_write = 1'b1;
    tick(); chk("mux2", pc1, 32'h1234_5678);

    pc_source = 3'd0; alu_result = 32'h24;
    tick(); chk("pc24", pc1, 32'h24);

    // exception with a simultaneous pc_write: request wins
    alu_result = 32'h999; exc_req = 1'b1; exc_code = 2'd2;
    tick();
    chk("exc_epc", epc1, 32'h20);
    chk("exc_pc_hold", pc1, 32'h24);
    chk("exc_rd", {31'd0, rd1}, 32'd1);
    chk("exc_addr", addr1, 32'd254);
    chk("exc_busy1", {31'd0, busy1}, 32'd1);
    exc_req = 1'b0; mem_data = 32'h0000_00A7;
    tick();
    chk("exc_rd_off", {31'd0, rd1}, 32'd0);
    chk("exc_busy2", {31'd0, busy1}, 32'd1);
    chk("exc_pc_wait", pc1, 32'h24);
    tick();
    chk("exc_busy3", {31'd0, busy1}, 32'd1);
    chk("exc_pc_load", pc1, 32'h24);
    tick();
    chk("exc_pc_new", pc1, 32'hA7);
    chk("exc_busy_end", {31'd0, busy1}, 32'd0);
    chk("exc_epc_keep", epc1, 32'h20);

    pc_source = 3'd4;
    tick(); chk("mux4_epc", pc1, 32'h20);
    for (int s = 5; s < 8; s++) begin
      pc_source = 3'(s);
      tick(); chk($sformatf("mux%0d_hold", s), pc1, 32'h20);
    end
    pc_write = 1'b0; pc_source = 3'd0;

    // exc_code 0 folds onto code 1; upper mem_data bits must be dropped
    exc_req = 1'b1; exc_code = 2'd0;
    tick();
    chk("code0_addr", addr1, 32'd253);
    chk("code0_epc", epc1, 32'h1C);
    exc_req = 1'b0; mem_data = 32'h55AA_33C4;
    tick(); tick(); tick();
    chk("zext_pc", pc1, 32'hC4);

    // reset while waiting for memory
    exc_req = 1'b1; exc_code = 2'd1;
    tick();
    exc_req = 1'b0; mem_data = 32'h0000_00EE;
    tick();
    chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_pc", pc1, 32'h0);
    chk("mid_rst_epc", epc1, 32'h0);
    chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
    chk("mid_rst_rd", {31'd0, rd1}, 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("no_late_load", pc1, 32'h0);
    chk("no_late_busy", {31'd0, busy1}, 32'd0);

    // latency sweep on MEM_LAT=0 and MEM_LAT=3 instances
    reset = 1'b1; tick(); reset = 1'b0;
    alu_result = 32'h100; pc_write = 1'b1;
    tick(); pc_write = 1'b0;
    chk("sw_pc0", pc0, 32'h100);
    chk("sw_pc3", pc3, 32'h100);
    exc_req = 1'b1; exc_code = 2'd3; mem_data = 32'h0000_003C; alu_result = 32'h777;
    tick();                                  // edge N
    exc_req = 1'b0; pc_write = 1'b1;
    chk("sw_addr3", addr3, 32'd255);
    chk("sw_epc3", epc3, 32'hFC);
    chk("sw_addr0", addr0, 32'd255);
    tick();                                  // N+1
    chk("l0_n1", pc0, 32'h100);
    tick();                                  // N+2
    pc_write = 1'b0;
    chk("l0_n2", pc0, 32'h3C);
    chk("l3_n2", pc3, 32'h100);
    tick();                                  // N+3
    chk("l3_n3", pc3, 32'h100);
    tick();                                  // N+4
    chk("l3_n4", pc3, 32'h100);
    chk("l3_busy_n4", {31'd0, busy3}, 32'd1);
    tick();                                  // N+5
    chk("l3_n5", pc3, 32'h3C);
    chk("l3_busy_n5", {31'd0, busy3}, 32'd0);
    chk("l0_busy_end", {31'd0, busy0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
